dcache: RTL

//  Direct-mapped, write-back, write-allocate data cache between the 8-bit CPU data port and the
//  32-bit-block data memory. Serves byte loads/stores from CPU; stalls CPU via BUSYWAIT on misses

---
 rtl/dcache_pkg.sv | 22 ++
 rtl/dcache_ctrl_fsm.sv | 77 +++++++
 rtl/dcache.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped data cache.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dcache_pkg;

  // CPU address and data widths; the memory bus moves one 32-bit block.
  localparam int ADDR_W       = 8;
  localparam int BYTE_W       = 8;
  localparam int BLOCK_W      = 32;

  // Default geometry: 8 blocks of 4 bytes.
  localparam int INDEX_W_DEF  = 3;
  localparam int OFFSET_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_e;

endpackage

// File: rtl/dcache_ctrl_fsm.sv
// Miss-handling controller: state register, next-state logic, memory request and CPU stall decode.
// Latency: decode is combinational from state and hit; one state transition per clock.
// Backpressure: holds WRITEBACK/FETCH until mem_busywait_i is low at a clock edge; stalls CPU outside IDLE.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   req_i, hit_i           CPU request present, lookup hit for current address
//   victim_dirty_i         indexed line is valid and dirty (needs writeback on miss)
//   mem_busywait_i         memory still busy with current request
//   state_o                current controller state
//   busywait_o             CPU stall
//   mem_read_o/mem_write_o memory block read / write request
module dcache_ctrl_fsm
  import dcache_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   req_i,
  input  logic   hit_i,
  input  logic   victim_dirty_i,
  input  logic   mem_busywait_i,
  output state_e state_o,
  output logic   busywait_o,
  output logic   mem_read_o,
  output logic   mem_write_o
);

  state_e state_q, state_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    busywait_o  = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i && !hit_i) begin
          busywait_o = 1'b1;
          state_d    = victim_dirty_i ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        busywait_o  = 1'b1;
        mem_write_o = 1'b1;
        if (!mem_busywait_i) state_d = FETCH;
      end
      FETCH: begin
        busywait_o = 1'b1;
        mem_read_o = 1'b1;
        if (!mem_busywait_i) state_d = UPDATE;
      end
      UPDATE: begin
        busywait_o = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // While reset is held the CPU request may still be present with every
    // line invalid; keep the stall and memory strobes quiet regardless.
    if (rst_i) begin
      busywait_o  = 1'b0;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate byte cache between CPU data port and 32-bit block memory.
// Latency: hits 0 stall cycles; clean miss L+2, dirty miss 2L+2 stall cycles for memory latency L.
// Backpressure: BUSYWAIT stalls the CPU during misses; memory requests held until MEM_BUSYWAIT drops.
//
// Ports:
//   CLK, RESET                          clock, asynchronous active-high reset
//   ADDRESS, WRITEDATA                  CPU byte address {tag,index,offset} and store data
//   MEMREAD, MEMWRITE                   CPU load / store request (both high = load)
//   READDATA, BUSYWAIT                  load data and CPU stall
//   MEM_ADDRESS, MEM_WRITEDATA          memory block address {tag,index} and victim block
//   MEM_READDATA, MEM_BUSYWAIT          fetched block and memory busy
//   MEM_READ, MEM_WRITE                 memory block read / write request
module dcache
  import dcache_pkg::*;
#(
  parameter int INDEX_W  = INDEX_W_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [ADDR_W-1:0]          ADDRESS,
  input  logic [BYTE_W-1:0]          WRITEDATA,
  input  logic                       MEMREAD,
  input  logic                       MEMWRITE,
  output logic [BYTE_W-1:0]          READDATA,
  output logic                       BUSYWAIT,
  output logic [ADDR_W-OFFSET_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]         MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]         MEM_READDATA,
  output logic                       MEM_READ,
  output logic                       MEM_WRITE,
  input  logic                       MEM_BUSYWAIT
);

  localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
  localparam int NUM_BLOCKS = 2 ** INDEX_W;
  localparam int NUM_BYTES  = BLOCK_W / BYTE_W;

  // Line storage. Data and tags need no reset: valid gates every use.
  logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid_q, valid_d;
  logic [NUM_BLOCKS-1:0] dirty_q, dirty_d;

  // Miss address captured on entry to miss handling so the refill lands in
  // the right line even if the CPU drops or changes its request meanwhile.
  logic [TAG_W-1:0]      miss_tag_q, miss_tag_d;
  logic [INDEX_W-1:0]    miss_idx_q, miss_idx_d;

  logic [BYTE_W-1:0]     rdata_q, rdata_d;

  logic [TAG_W-1:0]      addr_tag;
  logic [INDEX_W-1:0]    addr_idx;
  logic [OFFSET_W-1:0]   addr_off;
  logic [BLOCK_W-1:0]    hit_blk;
  logic [BLOCK_W-1:0]    wr_blk;
  logic [BYTE_W-1:0]     sel_byte;
  logic                  req, hit, victim_dirty, ld_hit, wr_hit, miss_start;
  logic [INDEX_W-1:0]    cur_idx;
  logic [TAG_W-1:0]      cur_tag;
  state_e                state;

  assign addr_tag = ADDRESS[ADDR_W-1 -: TAG_W];
  assign addr_idx = ADDRESS[OFFSET_W +: INDEX_W];
  assign addr_off = ADDRESS[OFFSET_W-1:0];

  assign req          = MEMREAD | MEMWRITE;
  assign hit          = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
  assign victim_dirty = valid_q[addr_idx] & dirty_q[addr_idx];
  assign hit_blk      = data_q[addr_idx];

  // Load wins when both strobes are high, so a store only counts alone.
  assign ld_hit     = (state == IDLE) && MEMREAD && hit;
  assign wr_hit     = (state == IDLE) && MEMWRITE && !MEMREAD && hit;
  assign miss_start = (state == IDLE) && req && !hit;

  // Byte extract for loads and byte merge for stores.
  always_comb begin
    sel_byte = '0;
    wr_blk   = hit_blk;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (addr_off == OFFSET_W'(b)) begin
        sel_byte                    = hit_blk[b*BYTE_W +: BYTE_W];
        wr_blk[b*BYTE_W +: BYTE_W]  = WRITEDATA;
      end
    end
  end

  dcache_ctrl_fsm u_ctrl (
    .clk_i          (CLK),
    .rst_i          (RESET),
    .req_i          (req),
    .hit_i          (hit),
    .victim_dirty_i (victim_dirty),
    .mem_busywait_i (MEM_BUSYWAIT),
    .state_o        (state),
    .busywait_o     (BUSYWAIT),
    .mem_read_o     (MEM_READ),
    .mem_write_o    (MEM_WRITE)
  );

  // Outside IDLE the line being worked on is the captured miss line.
  assign cur_idx = (state == IDLE) ? addr_idx : miss_idx_q;
  assign cur_tag = (state == IDLE) ? addr_tag : miss_tag_q;

  assign MEM_ADDRESS   = (state == WRITEBACK) ? {tag_q[cur_idx], cur_idx} : {cur_tag, cur_idx};
  assign MEM_WRITEDATA = data_q[cur_idx];

  always_comb begin
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    rdata_d    = rdata_q;
    if (state == UPDATE) begin
      valid_d[miss_idx_q] = 1'b1;
      dirty_d[miss_idx_q] = 1'b0;
    end else if (wr_hit) begin
      dirty_d[addr_idx] = 1'b1;
    end
    if (miss_start) begin
      miss_tag_d = addr_tag;
      miss_idx_d = addr_idx;
    end
    // READDATA keeps its last value when there is no load hit.
    if (ld_hit) rdata_d = sel_byte;
  end

  assign READDATA = RESET ? '0 : rdata_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      rdata_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      rdata_q    <= rdata_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (state == UPDATE) begin
      data_q[miss_idx_q] <= MEM_READDATA;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end else if (wr_hit) begin
      data_q[addr_idx] <= wr_blk;
    end
  end

endmodule
